alu_issuer: RTL
===============

# alu_issuer

Execute-stage initiator for the single-cycle ALU. It accepts one decoded instruction plus its operand pair from decode via valid/ready, drives the ALU's `enabled`/`instr`/`register` inputs, and captures `result` once `completed` is seen. It then resolves control flow (next PC, branch taken) and the memory address, and presents everything to writeback/memory through a second valid/ready handshake. One instruction is in flight at a time.

## Interface
- `TIMEOUT`, default 8: max cycles spent in WAIT before `err` is raised and the instruction is retired with `err=1`.
- `clk` in 1: clock; all state updates on posedge.
- `rstn` in 1: synchronous, active-low reset.
- `in_valid` in 1: decode has an instruction.
- `in_ready` out 1: issuer can accept.
- `in_instr` in `instructions`: decoded instruction (uses `pc`, `imm`, the branch/jump flags and the load/store flags).
- `in_register` in `regvpair`: operand values `rs1`, `rs2`.
- `alu_enabled` out 1: one-cycle start pulse to the ALU.
- `alu_instr` out `instructions`: held instruction.
- `alu_register` out `regvpair`: held operands.
- `alu_completed` in 1: ALU result valid qualifier.
- `alu_result` in 32: ALU result.
- `out_valid` out 1: retired instruction available.
- `out_ready` in 1: downstream accepts.
- `out_instr` out `instructions`: the instruction being retired.
- `out_result` out 32: captured ALU result (rd value or memory address).
- `out_next_pc` out 32: resolved next PC.
- `out_taken` out 1: control transfer (taken branch, jal or jalr).
- `out_is_mem` out 1: instruction is a load or store; `out_result` is then the address.
- `err` out 1: timeout occurred on the retiring instruction.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid`, latch `in_instr`/`in_register` into the hold registers and go to ISSUE.
- ISSUE:
  - `alu_enabled=1` for exactly this cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - `alu_enabled=0`.
  - Because `alu_completed` may be sticky high from earlier operations, it is only honoured in WAIT, i.e. at least one edge after the enable pulse.
  - On `alu_completed=1`:
    - capture `alu_result`;
    - compute next PC, `taken` and `is_mem`;
    - `err=0`;
    - go to DONE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT-1` without completion: capture `out_result=0`, `out_next_pc=pc+4`, `taken=0`, `err=1`, and go to DONE.
- DONE:
  - `out_valid=1`; all `out_*` and `err` are held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready` stays 0 in DONE (no bypass), even when `out_ready=1` in the same cycle.
- Control resolution (all arithmetic 32-bit, wraps mod 2^32):
  - Conditional branch (beq/bne/blt/bge/bltu/bgeu): `taken=alu_result[0]`. Next PC is `pc+imm` if taken, else `pc+4`.
  - `jal`: `taken=1`, next PC is `pc+imm`.
  - `jalr`: `taken=1`, next PC is `(rs1+imm) & 32'hFFFF_FFFE`, using the held operands.
  - All other instructions: `taken=0`, next PC is `pc+4`.
  - Loads/stores (lb, lh, lw, lbu, lhu, sb, sh, sw): `is_mem=1`.
- `alu_instr`/`alu_register` always reflect the hold registers and are stable from ISSUE through DONE.
- Reset:
  - State goes to IDLE.
  - `alu_enabled`, `out_valid`, `out_taken`, `out_is_mem` and `err` go to 0.
  - `out_result` and `out_next_pc` go to 0.
  - `in_ready` is 1 after the first post-reset edge.
  - Reset mid-operation in any state abandons the instruction without producing an output.

## Timing
- Edge 0: accept edge (IDLE with `in_valid`).
- Cycle 1: ISSUE (enable high).
- Cycle 2: WAIT with a responsive ALU (completed sampled).
- Cycle 3: DONE with `out_valid=1`.
- With immediate `out_ready`, IDLE is re-entered at cycle 4. Minimum issue interval is 4 cycles.
- Latency from accept to `out_valid` is 3 cycles plus any additional WAIT cycles.
- Timeout path reaches DONE at cycle `2+TIMEOUT`.
- `in_valid` deasserted in IDLE: no state change.
- `out_ready` held low: DONE persists indefinitely with stable outputs.

## Test plan
- addi, pc=0x100, rs1=5, imm=7, ALU returns 12 → one `alu_enabled` pulse; `out_result=12`, `out_next_pc=0x104`, `taken=0`, `out_valid` 3 cycles after accept.
- beq, pc=0x200, imm=0xFFFFFFF0, result=1 → `taken=1`, `next_pc=0x1F0`. Same with result=0 → `taken=0`, `next_pc=0x204`.
- jalr, pc=0x40, rs1=0x1001, imm=4, result=0x44 → `next_pc=0x1004`, `taken=1`, `out_result=0x44`.
- lw, result=0x8000_0010 → `is_mem=1`, `out_result=0x8000_0010`. Hold `out_ready=0` for 5 cycles → outputs stable, `in_ready=0` throughout.
- `alu_completed` stuck 0, `TIMEOUT=8` → `err=1`, `out_result=0`, `next_pc=pc+4` at cycle 10. `alu_completed` stuck 1 → still exactly one enable pulse, capture in WAIT.
- `rstn=0` during WAIT → next cycle: IDLE, `out_valid=0`, `alu_enabled=0`, `in_ready=1`, no retirement.

Source files
------------

// File: rtl/alu_issuer.sv
// alu_issuer: execute-stage initiator for the single-cycle ALU.
// Accepts one decoded instruction from decode, pulses the ALU, captures the
// result, resolves control flow and the memory address, and hands the retired
// instruction to writeback/memory. One instruction is in flight at a time.

package alu_issuer_pkg;

  // Decoded instruction: PC, immediate, register indices and one-hot op flags.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        lui;
    logic        auipc;
    logic        jal;
    logic        jalr;
    logic        beq;
    logic        bne;
    logic        blt;
    logic        bge;
    logic        bltu;
    logic        bgeu;
    logic        lb;
    logic        lh;
    logic        lw;
    logic        lbu;
    logic        lhu;
    logic        sb;
    logic        sh;
    logic        sw;
    logic        addi;
    logic        slti;
    logic        sltiu;
    logic        xori;
    logic        ori;
    logic        andi;
    logic        slli;
    logic        srli;
    logic        srai;
    logic        add;
    logic        sub;
    logic        sll;
    logic        slt;
    logic        sltu;
    logic        xor_;
    logic        srl;
    logic        sra;
    logic        or_;
    logic        and_;
  } instructions;

  // Operand values read from the register file for rs1 and rs2.
  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
  } regvpair;

endpackage

module alu_issuer
  import alu_issuer_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  instructions in_instr,
  input  regvpair     in_register,
  output logic        alu_enabled,
  output instructions alu_instr,
  output regvpair     alu_register,
  input  logic        alu_completed,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output instructions out_instr,
  output logic [31:0] out_result,
  output logic [31:0] out_next_pc,
  output logic        out_taken,
  output logic        out_is_mem,
  output logic        err
);

  // The WAIT counter must represent TIMEOUT-1; one spare bit keeps TIMEOUT=1 legal.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  instructions    holdInstr_q, holdInstr_d;
  regvpair        holdRegs_q, holdRegs_d;
  logic [CW-1:0]  timer_q, timer_d;
  logic [31:0]    result_q, result_d;
  logic [31:0]    nextPc_q, nextPc_d;
  logic           taken_q, taken_d;
  logic           isMem_q, isMem_d;
  logic           err_q, err_d;

  logic           isBranch;
  logic           isMemOp;
  logic [31:0]    seqPc;
  logic [31:0]    targetPc;
  logic [31:0]    jalrSum;
  logic [31:0]    resolvedPc;
  logic           resolvedTaken;

  // Resolve control flow and memory classification from the held instruction and live ALU result.
  always_comb begin
    isBranch      = holdInstr_q.beq | holdInstr_q.bne | holdInstr_q.blt |
                    holdInstr_q.bge | holdInstr_q.bltu | holdInstr_q.bgeu;
    isMemOp       = holdInstr_q.lb | holdInstr_q.lh | holdInstr_q.lw |
                    holdInstr_q.lbu | holdInstr_q.lhu |
                    holdInstr_q.sb | holdInstr_q.sh | holdInstr_q.sw;
    seqPc         = holdInstr_q.pc + 32'd4;
    targetPc      = holdInstr_q.pc + holdInstr_q.imm;
    jalrSum       = holdRegs_q.rs1 + holdInstr_q.imm;
    resolvedPc    = seqPc;
    resolvedTaken = 1'b0;
    if (holdInstr_q.jal) begin
      resolvedTaken = 1'b1;
      resolvedPc    = targetPc;
    end else if (holdInstr_q.jalr) begin
      resolvedTaken = 1'b1;
      resolvedPc    = jalrSum & 32'hFFFF_FFFE;
    end else if (isBranch) begin
      resolvedTaken = alu_result[0];
      resolvedPc    = alu_result[0] ? targetPc : seqPc;
    end
  end

  // Next-state logic; completion is only honoured in WAIT because it may be sticky from earlier ops.
  always_comb begin
    state_d     = state_q;
    holdInstr_d = holdInstr_q;
    holdRegs_d  = holdRegs_q;
    timer_d     = timer_q;
    result_d    = result_q;
    nextPc_d    = nextPc_q;
    taken_d     = taken_q;
    isMem_d     = isMem_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          holdInstr_d = in_instr;
          holdRegs_d  = in_register;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_completed) begin
          result_d = alu_result;
          nextPc_d = resolvedPc;
          taken_d  = resolvedTaken;
          isMem_d  = isMemOp;
          err_d    = 1'b0;
          state_d  = DONE;
        end else if (timer_q == TIMER_LAST) begin
          result_d = 32'd0;
          nextPc_d = seqPc;
          taken_d  = 1'b0;
          isMem_d  = 1'b0;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          timer_d = timer_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      holdInstr_q <= '0;
      holdRegs_q  <= '0;
      timer_q     <= '0;
      result_q    <= '0;
      nextPc_q    <= '0;
      taken_q     <= 1'b0;
      isMem_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      holdInstr_q <= holdInstr_d;
      holdRegs_q  <= holdRegs_d;
      timer_q     <= timer_d;
      result_q    <= result_d;
      nextPc_q    <= nextPc_d;
      taken_q     <= taken_d;
      isMem_q     <= isMem_d;
      err_q       <= err_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign alu_enabled  = (state_q == ISSUE);
  assign out_valid    = (state_q == DONE);
  assign alu_instr    = holdInstr_q;
  assign alu_register = holdRegs_q;
  assign out_instr    = holdInstr_q;
  assign out_result   = result_q;
  assign out_next_pc  = nextPc_q;
  assign out_taken    = taken_q;
  assign out_is_mem   = isMem_q;
  assign err          = err_q;

endmodule
